// File: rtl/ps2_keycode_rx.sv
`default_nettype none
// ============================================================================
// ps2_keycode_rx : PS/2 keyboard frame receiver with make/break/mode decoding
// rev 1.0
// ============================================================================
module ps2_keycode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic [1:0] released,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, STOP, CHECK} state_t;

  state_t        state, state_nxt;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_lvl, strobe;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    bitcnt;
  logic [8:0]    shreg;
  logic          stop_bit;
  logic          brk, ext;
  logic          in_frame, timeout, frame_good;
  logic [7:0]    b;

  // Synchronizers and clock filter; strobe marks a filtered falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_lvl <= 1'b1;
      filt_cnt <= '0;
      strobe   <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      strobe <= 1'b0;
      if (clk_s2 != filt_lvl) begin
        if (filt_cnt == FILT_MAX) begin
          filt_lvl <= clk_s2;
          filt_cnt <= '0;
          strobe   <= ~clk_s2;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign in_frame   = (state == SHIFT) || (state == STOP);
  assign timeout    = in_frame && !strobe && (to_cnt == TO_MAX);
  assign frame_good = (^shreg) && stop_bit;
  assign b          = shreg[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (strobe && !dat_s2) state_nxt = SHIFT;
      SHIFT: begin
        if (timeout)                         state_nxt = IDLE;
        else if (strobe && bitcnt == 4'd8)   state_nxt = STOP;
      end
      STOP: begin
        if (timeout)     state_nxt = IDLE;
        else if (strobe) state_nxt = CHECK;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt     <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      stop_bit   <= 1'b0;
      brk        <= 1'b0;
      ext        <= 1'b0;
      data       <= 8'h00;
      released   <= 2'd0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      to_cnt     <= (in_frame && !strobe) ? to_cnt + TW'(1) : '0;
      if (state == IDLE) bitcnt <= '0;
      if (state == SHIFT && strobe) begin
        shreg  <= {dat_s2, shreg[8:1]};
        bitcnt <= bitcnt + 4'd1;
      end
      if (state == STOP && strobe) stop_bit <= dat_s2;
      if (timeout) begin
        frame_err <= 1'b1;
        brk       <= 1'b0;
        ext       <= 1'b0;
      end
      if (state == CHECK) begin
        if (frame_good) begin
          code_valid <= 1'b1;
          // Prefixes accumulate (E0 F0 xx); any other byte consumes them.
          ext <= (b == 8'hE0) | (ext & (b == 8'hF0));
          brk <= (b == 8'hF0) | (brk & (b == 8'hE0));
          if (b != 8'hE0 && b != 8'hF0) begin
            if (brk) begin
              if (b == data) data <= 8'h00;
            end else begin
              case (b)
                8'h4D:   released <= 2'd1;
                8'h2D:   released <= 2'd2;
                8'h76:   released <= 2'd0;
                default: data     <= b;
              endcase
            end
          end
        end else begin
          frame_err <= 1'b1;
          brk       <= 1'b0;
          ext       <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keycode_rx.sv
`default_nettype none
// ============================================================================
// tb_ps2_keycode_rx : table, directed and random checks against a keyboard model
// rev 1.0
// ============================================================================
module tb_ps2_keycode_rx;

  localparam int FL   = 4;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic [1:0] released;
  logic       code_valid;
  logic       frame_err;

  ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .released(released), .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cv_cnt = 0;
  int fe_cnt = 0;
  always @(posedge clk) begin
    if (code_valid) cv_cnt <= cv_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  // Keyboard-level model of the decoder
  logic [7:0] m_data;
  logic [1:0] m_rel;
  bit         m_brk, m_ext;
  int         exp_cv, exp_fe;

  task automatic model_reset();
    m_data = 8'h00; m_rel = 2'd0; m_brk = 0; m_ext = 0;
  endtask

  task automatic model(input logic [7:0] byt, input bit good);
    if (!good) begin
      m_brk = 0; m_ext = 0; exp_fe++;
    end else begin
      exp_cv++;
      if (byt == 8'hE0) m_ext = 1;
      else if (byt == 8'hF0) m_brk = 1;
      else if (m_brk) begin
        if (byt == m_data) m_data = 8'h00;
        m_brk = 0; m_ext = 0;
      end else begin
        if (byt == 8'h4D)      m_rel = 2'd1;
        else if (byt == 8'h2D) m_rel = 2'd2;
        else if (byt == 8'h76) m_rel = 2'd0;
        else                   m_data = byt;
        m_ext = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] byt, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^byt) ^ bad_par, byt, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] byt, input bit bad_par, input bit bad_stop);
    send_bits(mk_frame(byt, bad_par, bad_stop), 11);
    ps2_data = 1'b1;
    wait_cyc(3 * HALF);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".data"}, 32'(data), 32'(m_data));
    chk({tag, ".released"}, 32'(released), 32'(m_rel));
    chk({tag, ".code_valid_cnt"}, 32'(cv_cnt), 32'(exp_cv));
    chk({tag, ".frame_err_cnt"}, 32'(fe_cnt), 32'(exp_fe));
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] exp_data;
    logic [1:0] exp_rel;
  } vec_t;

  vec_t vecs[25];

  initial begin
    logic [10:0] f;
    logic [7:0]  rb;
    bit          rbad, rpar;
    int          sel;

    vecs[0]  = '{8'h1D, 0, 0, 8'h1D, 2'd0};
    vecs[1]  = '{8'hF0, 0, 0, 8'h1D, 2'd0};
    vecs[2]  = '{8'h1D, 0, 0, 8'h00, 2'd0};
    vecs[3]  = '{8'hE0, 0, 0, 8'h00, 2'd0};
    vecs[4]  = '{8'h75, 0, 0, 8'h75, 2'd0};
    vecs[5]  = '{8'hE0, 0, 0, 8'h75, 2'd0};
    vecs[6]  = '{8'hF0, 0, 0, 8'h75, 2'd0};
    vecs[7]  = '{8'h75, 0, 0, 8'h00, 2'd0};
    vecs[8]  = '{8'h2D, 0, 0, 8'h00, 2'd2};
    vecs[9]  = '{8'h4D, 0, 0, 8'h00, 2'd1};
    vecs[10] = '{8'h76, 0, 0, 8'h00, 2'd0};
    vecs[11] = '{8'h1C, 1, 0, 8'h00, 2'd0};
    vecs[12] = '{8'h1C, 0, 0, 8'h1C, 2'd0};
    vecs[13] = '{8'h1C, 0, 0, 8'h1C, 2'd0};
    vecs[14] = '{8'h23, 0, 0, 8'h23, 2'd0};
    vecs[15] = '{8'hF0, 0, 0, 8'h23, 2'd0};
    vecs[16] = '{8'h1C, 0, 0, 8'h23, 2'd0};
    vecs[17] = '{8'h2D, 0, 0, 8'h23, 2'd2};
    vecs[18] = '{8'hF0, 0, 0, 8'h23, 2'd2};
    vecs[19] = '{8'h44, 1, 0, 8'h23, 2'd2};
    vecs[20] = '{8'h23, 0, 0, 8'h23, 2'd2};
    vecs[21] = '{8'hF0, 0, 0, 8'h23, 2'd2};
    vecs[22] = '{8'h23, 0, 0, 8'h00, 2'd2};
    vecs[23] = '{8'hF0, 0, 1, 8'h00, 2'd2};
    vecs[24] = '{8'h76, 0, 0, 8'h00, 2'd0};

    model_reset();
    exp_cv = 0;
    exp_fe = 0;

    wait_cyc(5);
    chk("reset.data", 32'(data), 32'h00);
    chk("reset.released", 32'(released), 32'd0);
    chk("reset.code_valid", 32'(code_valid), 32'd0);
    chk("reset.frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    wait_cyc(20);

    for (int i = 0; i < 25; i++) begin
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
      model(vecs[i].code, !(vecs[i].bad_par || vecs[i].bad_stop));
      chk($sformatf("vec%0d.data", i), 32'(data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d.released", i), 32'(released), 32'(vecs[i].exp_rel));
      chk($sformatf("vec%0d.cv_cnt", i), 32'(cv_cnt), 32'(exp_cv));
      chk($sformatf("vec%0d.fe_cnt", i), 32'(fe_cnt), 32'(exp_fe));
    end

    // Timeout: a break prefix, then a frame that stalls after four data bits
    send_frame(8'hF0, 0, 0);
    model(8'hF0, 1);
    send_bits(mk_frame(8'h23, 0, 0), 5);
    ps2_data = 1'b1;
    wait_cyc(TO + 1 + 30);
    model(8'h00, 0);
    chk_state("timeout");
    send_frame(8'h23, 0, 0);
    model(8'h23, 1);
    chk_state("after_timeout");

    // Glitches on ps2_clk shorter than the filter length
    ps2_data = 1'b0;
    for (int w = 1; w < FL; w++) begin
      ps2_clk = 1'b0;
      wait_cyc(w);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    ps2_data = 1'b1;
    wait_cyc(HALF);
    chk_state("glitch");
    send_frame(8'h5A, 0, 0);
    model(8'h5A, 1);
    chk_state("after_glitch");

    // Reset during bit 5 with a held key and record mode
    send_frame(8'h75, 0, 0);
    model(8'h75, 1);
    send_frame(8'h2D, 0, 0);
    model(8'h2D, 1);
    chk_state("pre_reset");
    f = mk_frame(8'hA5, 0, 0);
    send_bits(f, 6);
    ps2_data = f[6];
    wait_cyc(5);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    model_reset();
    chk("midreset.data", 32'(data), 32'h00);
    chk("midreset.released", 32'(released), 32'd0);
    chk("midreset.code_valid", 32'(code_valid), 32'd0);
    chk("midreset.frame_err", 32'(frame_err), 32'd0);
    ps2_data = 1'b1;
    wait_cyc(100);
    chk_state("post_reset_idle");
    send_frame(8'h1B, 0, 0);
    model(8'h1B, 1);
    chk_state("after_reset");

    // Random keyboard traffic against the model
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        2: begin
          case ($urandom_range(0, 2))
            0:       rb = 8'h4D;
            1:       rb = 8'h2D;
            default: rb = 8'h76;
          endcase
        end
        3: rb = m_data;
        default: rb = 8'($urandom);
      endcase
      rbad = ($urandom_range(0, 7) == 0);
      rpar = ($urandom_range(0, 1) == 0);
      send_frame(rb, rbad && rpar, rbad && !rpar);
      model(rb, !rbad);
      chk_state($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
